video_sync_gen: RTL and testbench

- Upstream timing stage for the image noise-reduction sim/test environment.
- Generates the 3-bit sync bus Synco[26:24] that the pixel source consumes as its Synci input.
  - Bit 26: frame-start pulse.
  - Bit 25: line-start pulse.
  - Bit 24: pixel-valid / data enable.
- Raster geometry is programmable, including blanking.
- Start/stop run control, optional fixed frame count, and frame-done/busy status for the testbench.

---
 rtl/video_sync_gen_if.sv | 30 +++
 rtl/video_sync_gen.sv | 145 ++++++++++++++
 tb/tb_video_sync_gen.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/video_sync_gen_if.sv
// Run-control and sync/status bundle between the raster timing generator and its consumer.
// The generator drives the sync bus and status; the consumer drives start/stop.
interface video_sync_gen_if #(
    parameter int CW = 16
);
    logic          start;
    logic          stop;
    logic [26:24]  Synco;
    logic          busy;
    logic          frame_done;
    logic [CW-1:0] frame_cnt;

    modport master (
        input  start,
        input  stop,
        output Synco,
        output busy,
        output frame_done,
        output frame_cnt
    );

    modport slave (
        output start,
        output stop,
        input  Synco,
        input  busy,
        input  frame_done,
        input  frame_cnt
    );
endinterface

// File: rtl/video_sync_gen.sv
// Programmable raster timing generator: frame/line/data-enable sync bus with run control.
// Blanking precedes active area on both axes; all outputs trail the counters by one cycle.
module video_sync_gen #(
    parameter int H_ACT      = 640,
    parameter int H_BLANK    = 160,
    parameter int V_ACT      = 480,
    parameter int V_BLANK    = 45,
    parameter int NUM_FRAMES = 0,
    parameter int CW         = 16
) (
    input  logic             clk,
    input  logic             rst,
    video_sync_gen_if.master bus
);

    if (H_ACT < 1 || H_BLANK < 1 || V_ACT < 1 || V_BLANK < 1) begin : g_bad_geometry
        $fatal(1, "video_sync_gen: degenerate raster geometry");
    end

    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] H_LAST  = CW'(H_ACT + H_BLANK - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_ACT + V_BLANK - 1);
    localparam logic [CW-1:0] H_FIRST = CW'(H_BLANK);
    localparam logic [CW-1:0] V_FIRST = CW'(V_BLANK);
    localparam logic [CW-1:0] NF      = CW'(NUM_FRAMES);
    localparam bit            COUNTED = (NUM_FRAMES != 32'sd0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;
    logic [2:0]    synco_q, synco_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;

    logic active_s;
    logic h_end_s;
    logic frame_end_s;
    logic last_frame_s;

    // Next-state, counter and output decode from the current (state, h, v).
    always_comb begin
        active_s     = (state_q != S_IDLE);
        h_end_s      = (h_q == H_LAST);
        frame_end_s  = active_s && h_end_s && (v_q == V_LAST);
        last_frame_s = COUNTED && ((frame_cnt_q + ONE) == NF);

        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d     = S_RUN;
                    frame_cnt_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // A stop landing on the final cycle ends the run without a drain pass.
                if (frame_end_s) begin
                    if (bus.stop || last_frame_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RUN;
                    end
                end else if (bus.stop) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (frame_end_s) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (frame_end_s) begin
            frame_cnt_d = frame_cnt_q + ONE;
        end else begin
            frame_cnt_d = frame_cnt_d;
        end

        if (!active_s) begin
            h_d = '0;
            v_d = '0;
        end else if (h_end_s) begin
            h_d = '0;
            if (v_q == V_LAST) begin
                v_d = '0;
            end else begin
                v_d = v_q + ONE;
            end
        end else begin
            h_d = h_q + ONE;
            v_d = v_q;
        end

        synco_d[2]   = active_s && (h_q == '0) && (v_q == '0);
        synco_d[1]   = active_s && (h_q == '0);
        synco_d[0]   = active_s && (h_q >= H_FIRST) && (v_q >= V_FIRST);
        busy_d       = active_s;
        frame_done_d = frame_end_s;
    end

    // State, counters and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            h_q          <= '0;
            v_q          <= '0;
            frame_cnt_q  <= '0;
            synco_q      <= 3'b000;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_q          <= h_d;
            v_q          <= v_d;
            frame_cnt_q  <= frame_cnt_d;
            synco_q      <= synco_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.Synco      = synco_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_video_sync_gen.sv
// Bench for video_sync_gen: two small-geometry instances (counted and continuous run)
// compared every cycle against a raster-position reference model.
module tb_video_sync_gen;

    localparam int HA = 4;
    localparam int HB = 2;
    localparam int VA = 3;
    localparam int VB = 1;
    localparam int HT = HA + HB;
    localparam int FL = HT * (VA + VB);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    video_sync_gen_if #(.CW(16)) if_a ();
    video_sync_gen_if #(.CW(16)) if_b ();

    video_sync_gen #(.H_ACT(HA), .H_BLANK(HB), .V_ACT(VA), .V_BLANK(VB), .NUM_FRAMES(2), .CW(16))
        u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
    video_sync_gen #(.H_ACT(HA), .H_BLANK(HB), .V_ACT(VA), .V_BLANK(VB), .NUM_FRAMES(0), .CW(16))
        u_dut_b (.clk(clk), .rst(rst), .bus(if_b));

    logic        start_i [2];
    logic        stop_i  [2];
    logic [2:0]  sy      [2];
    logic        bz      [2];
    logic        fd      [2];
    logic [15:0] fc      [2];

    assign if_a.start = start_i[0];
    assign if_a.stop  = stop_i[0];
    assign if_b.start = start_i[1];
    assign if_b.stop  = stop_i[1];
    assign sy[0] = if_a.Synco;
    assign sy[1] = if_b.Synco;
    assign bz[0] = if_a.busy;
    assign bz[1] = if_b.busy;
    assign fd[0] = if_a.frame_done;
    assign fd[1] = if_b.frame_done;
    assign fc[0] = if_a.frame_cnt;
    assign fc[1] = if_b.frame_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: run flag, linear position in frame, frames done, stop latched.
    int nf     [2] = '{2, 0};
    bit m_run  [2];
    int m_pos  [2];
    int m_fc   [2];
    bit m_stp  [2];
    int de_cnt [2];

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_run[d] = 1'b0;
            m_pos[d] = 0;
            m_fc[d]  = 0;
            m_stp[d] = 1'b0;
        end
    endtask

    task automatic tick();
        logic [2:0] es  [2];
        bit         eb  [2];
        bit         efd [2];
        for (int d = 0; d < 2; d++) begin
            int hh;
            int vv;
            hh = m_pos[d] % HT;
            vv = m_pos[d] / HT;
            es[d]  = {m_run[d] && m_pos[d] == 0,
                      m_run[d] && hh == 0,
                      m_run[d] && hh >= HB && vv >= VB};
            eb[d]  = m_run[d];
            efd[d] = m_run[d] && m_pos[d] == FL - 1;
            if (rst) begin
                es[d] = 3'b000; eb[d] = 1'b0; efd[d] = 1'b0;
            end else if (!m_run[d]) begin
                if (start_i[d]) begin
                    m_run[d] = 1'b1; m_pos[d] = 0; m_fc[d] = 0; m_stp[d] = 1'b0;
                end
            end else if (m_pos[d] == FL - 1) begin
                m_fc[d]++;
                if (m_stp[d] || stop_i[d] || (nf[d] != 0 && m_fc[d] == nf[d])) m_run[d] = 1'b0;
                m_pos[d] = 0;
            end else begin
                if (stop_i[d]) m_stp[d] = 1'b1;
                m_pos[d]++;
            end
        end
        if (rst) model_reset();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("synco%0d", d), int'(sy[d]), int'(es[d]));
            chk($sformatf("busy%0d", d), int'(bz[d]), int'(eb[d]));
            chk($sformatf("fdone%0d", d), int'(fd[d]), int'(efd[d]));
            chk($sformatf("fcnt%0d", d), int'(fc[d]), m_fc[d] % 65536);
            de_cnt[d] += int'(sy[d][0]);
        end
    endtask

    // Mid-cycle asynchronous reset pulse; outputs must clear before the next edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_synco%0d", d), int'(sy[d]), 0);
            chk($sformatf("rst_busy%0d", d), int'(bz[d]), 0);
            chk($sformatf("rst_fcnt%0d", d), int'(fc[d]), 0);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic run_idle(input int max_ticks);
        int k;
        for (k = 0; k < max_ticks; k++) begin
            if (!m_run[0] && !m_run[1]) break;
            tick();
        end
        chk("idle_reached", k, (k < max_ticks) ? k : -1);
    endtask

    initial begin
        int k;
        start_i = '{1'b0, 1'b0};
        stop_i  = '{1'b0, 1'b0};
        model_reset();
        de_cnt = '{0, 0};
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        tick();

        // Counted run on A, continuous run on B stopped mid-frame 2 (v=1).
        start_i = '{1'b1, 1'b1};
        tick();
        start_i = '{1'b0, 1'b0};
        de_cnt = '{0, 0};
        for (k = 0; k < 200; k++) begin
            if (m_run[1] && m_fc[1] == 1 && m_pos[1] == HT + 2) break;
            tick();
        end
        chk("reach_v1", k, (k < 200) ? k : -1);
        stop_i[1] = 1'b1;
        tick();
        stop_i[1] = 1'b0;
        run_idle(200);
        for (int i = 0; i < 4; i++) tick();
        chk("de_total_a", de_cnt[0], 2 * HA * VA);
        chk("de_total_b", de_cnt[1], 2 * HA * VA);
        chk("fcnt_b_final", int'(fc[1]), 2);

        // Stop exactly on the last cycle of frame 1.
        start_i[1] = 1'b1;
        tick();
        start_i[1] = 1'b0;
        for (k = 0; k < 100; k++) begin
            if (m_run[1] && m_pos[1] == FL - 1) break;
            tick();
        end
        chk("reach_last", k, (k < 100) ? k : -1);
        stop_i[1] = 1'b1;
        tick();
        stop_i[1] = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("fcnt_b_stop_last", int'(fc[1]), 1);

        // Reset at h=3, v=2 during RUN, then a clean rerun.
        start_i[0] = 1'b1;
        tick();
        start_i[0] = 1'b0;
        for (k = 0; k < 100; k++) begin
            if (m_run[0] && m_pos[0] == 2 * HT + 3) break;
            tick();
        end
        chk("reach_h3v2", k, (k < 100) ? k : -1);
        async_reset();
        tick();
        start_i[0] = 1'b1;
        tick();
        start_i[0] = 1'b0;
        run_idle(200);

        // Start held through RUN and DRAIN: restarts only after an IDLE cycle.
        start_i = '{1'b1, 1'b1};
        for (int i = 0; i < 40; i++) tick();
        stop_i[1] = 1'b1;
        for (int i = 0; i < 90; i++) tick();
        start_i = '{1'b0, 1'b0};
        stop_i  = '{1'b0, 1'b0};
        run_idle(200);

        // Randomized run control with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            start_i[0] = ($urandom_range(0, 9) == 0);
            start_i[1] = ($urandom_range(0, 9) == 0);
            stop_i[0]  = ($urandom_range(0, 29) == 0);
            stop_i[1]  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 299) == 0) async_reset();
            tick();
        end
        start_i = '{1'b0, 1'b0};
        stop_i  = '{1'b1, 1'b1};
        run_idle(200);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
